wb_fifo_slave: RTL

Wishbone B3 classic slave with a synchronous 32-bit FIFO behind an 8-byte register window. It sits downstream of the data-side Wishbone mux, on one of the `fifo0`/`fifo1` slave ports decoded with mask `0xfffffff8`. Software pushes by writing the DATA register and pops by reading it. A STATUS/CTRL register reports fill state and provides flush and an interrupt enable.

---
 rtl/wb_fifo_slave.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo_slave
// Description : Wishbone B3 classic slave exposing a 32-bit FIFO through a
//               DATA register (push/pop) and a STATUS/CTRL register.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo_slave #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        irq_o
);

    localparam int                    c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL_COUNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]   c_COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);

    logic [31:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_irq_en;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_irq;
    logic [31:0]           r_dat;

    logic                  w_req;
    logic                  w_sel_ctrl;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ctrl_wr;
    logic                  w_flush;
    logic                  w_err_cond;
    logic                  w_irq_en_next;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [31:0]           w_status;
    logic                  w_unused;

    // The registered ack/err masks the request so each access commits once.
    assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_sel_ctrl = wb_adr_i[2];
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_empty    = (r_count == '0);

    assign w_push     = w_req & ~w_sel_ctrl &  wb_we_i & ~w_full;
    assign w_pop      = w_req & ~w_sel_ctrl & ~wb_we_i & ~w_empty;
    assign w_ctrl_wr  = w_req &  w_sel_ctrl &  wb_we_i & wb_sel_i[0];
    assign w_flush    = w_ctrl_wr & wb_dat_i[0];
    assign w_err_cond = ~w_sel_ctrl & (wb_we_i ? w_full : w_empty);

    assign w_irq_en_next = w_ctrl_wr ? wb_dat_i[2] : r_irq_en;

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push) begin
            w_count_next = r_count + c_COUNT_ONE;
        end else if (w_pop) begin
            w_count_next = r_count - c_COUNT_ONE;
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[0]               = w_empty;
        w_status[1]               = w_full;
        w_status[2]               = r_irq_en;
        w_status[DEPTH_LOG2+8:8]  = r_count;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
            r_dat    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_irq_en <= 1'b0;
        end else begin
            r_ack    <= w_req & ~w_err_cond;
            r_err    <= w_req &  w_err_cond;
            r_count  <= w_count_next;
            r_irq_en <= w_irq_en_next;
            r_irq    <= w_irq_en_next & (w_count_next != '0);

            if (w_req & ~wb_we_i) begin
                r_dat <= w_sel_ctrl ? w_status : (w_empty ? '0 : r_mem[r_rd_ptr]);
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage is deliberately left out of reset; flush only moves pointers.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wb_dat_i;
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = 1'b0;
    assign irq_o    = r_irq;

    assign w_unused = ^{wb_adr_i[31:3], wb_adr_i[1:0], wb_sel_i[3:1],
                        wb_cti_i, wb_bte_i};

endmodule
`default_nettype wire
